// File: rtl/furv_pkg.sv
// Shared RV32I definitions for the furv pipeline: opcodes, ctrl bit positions
// and immediate format selection.
package furv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int CTRL_W         = 8;
  localparam int CTRL_IS_LUI    = 7;
  localparam int CTRL_IS_AUIPC  = 6;
  localparam int CTRL_IS_JAL    = 5;
  localparam int CTRL_IS_JALR   = 4;
  localparam int CTRL_IS_BRANCH = 3;
  localparam int CTRL_IS_LOAD   = 2;
  localparam int CTRL_IS_STORE  = 1;
  localparam int CTRL_IS_OP_IMM = 0;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // R-type and unrecognised opcodes carry no immediate.
  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OPC_LUI, OPC_AUIPC:               t = IMM_U;
      OPC_JAL:                          t = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:   t = IMM_I;
      OPC_BRANCH:                       t = IMM_B;
      OPC_STORE:                        t = IMM_S;
      default:                          t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/furv_imm_gen.sv
// Combinational RV32I immediate generator, shared by decode and later stages.
module furv_imm_gen
  import furv_pkg::*;
(
  input  logic [31:0] instruction,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  logic [31:0] i;
  assign i = instruction;

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'b0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/furv_id.sv
// furv decode stage: regfile read, immediate/control decode, load-use bubble
// insertion and the ID/EX pipeline register.
module furv_id
  import furv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [31:0]       instruction,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   rs1_val,
  output logic [XLEN-1:0]   rs2_val,
  output logic [XLEN-1:0]   imm,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic              alu_alt,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal,
  output logic              valid_o
);

  logic [6:0]        opcode;
  logic [CTRL_W-1:0] ctrl_d;
  logic              illegal_d;
  logic [4:0]        rd_d;
  logic              alu_alt_d;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              load_use;
  logic [31:0]       imm_d;
  imm_type_e         imm_type;

  assign opcode   = instruction[6:0];
  assign rs1_addr = instruction[19:15];
  assign rs2_addr = instruction[24:20];
  assign imm_type = imm_type_of(opcode);

  furv_imm_gen u_imm_gen (
    .instruction (instruction),
    .imm_type    (imm_type),
    .imm         (imm_d)
  );

  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b0;
    alu_alt_d = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_LUI:    begin ctrl_d[CTRL_IS_LUI]   = 1'b1; uses_rs1 = 1'b0; end
      OPC_AUIPC:  begin ctrl_d[CTRL_IS_AUIPC] = 1'b1; uses_rs1 = 1'b0; end
      OPC_JAL:    begin ctrl_d[CTRL_IS_JAL]   = 1'b1; uses_rs1 = 1'b0; end
      OPC_JALR:   ctrl_d[CTRL_IS_JALR] = 1'b1;
      OPC_BRANCH: begin ctrl_d[CTRL_IS_BRANCH] = 1'b1; uses_rs2 = 1'b1; end
      OPC_LOAD:   ctrl_d[CTRL_IS_LOAD] = 1'b1;
      OPC_STORE:  begin ctrl_d[CTRL_IS_STORE] = 1'b1; uses_rs2 = 1'b1; end
      OPC_OP_IMM: begin
        ctrl_d[CTRL_IS_OP_IMM] = 1'b1;
        // Only the right shifts use bit 30 (SRLI vs SRAI).
        alu_alt_d = (instruction[14:12] == 3'b101) ? instruction[30] : 1'b0;
      end
      OPC_OP:     begin alu_alt_d = instruction[30]; uses_rs2 = 1'b1; end
      default:    illegal_d = 1'b1;
    endcase
  end

  always_comb begin
    rd_d = instruction[11:7];
    if (illegal_d || ctrl_d[CTRL_IS_BRANCH] || ctrl_d[CTRL_IS_STORE])
      rd_d = 5'd0;
  end

  assign load_use = HAZARD_EN && valid_o && ctrl[CTRL_IS_LOAD] && (rd != 5'd0) && valid_i
                    && ((uses_rs1 && (rd == rs1_addr)) || (uses_rs2 && (rd == rs2_addr)));

  assign stall_o = stall_i | load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc   <= '0;
      rs1_val <= '0;
      rs2_val <= '0;
      imm     <= '0;
      rd      <= '0;
      funct3  <= '0;
      alu_alt <= 1'b0;
      ctrl    <= '0;
      illegal <= 1'b0;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (load_use) begin
        valid_o <= 1'b0;
      end else begin
        id_pc   <= if_pc;
        rs1_val <= rs1_data;
        rs2_val <= rs2_data;
        imm     <= imm_d;
        rd      <= rd_d;
        funct3  <= instruction[14:12];
        alu_alt <= alu_alt_d;
        ctrl    <= ctrl_d;
        illegal <= illegal_d;
        valid_o <= valid_i;
      end
    end
  end

endmodule

// File: tb/tb_furv_id.sv
// Directed bench for furv_id: expected outputs are queued when stimulus is
// driven and popped one cycle later when the pipeline register updates.
module tb_furv_id;

  typedef struct {
    int          lvl;   // 0: valid_o only, 1: all but imm, 2: everything
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        alt;
    logic [7:0]  ctrl;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] instruction;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] id_pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        alu_alt;
  logic [7:0]  ctrl;
  logic        illegal;
  logic        valid_o;

  int   checks;
  int   failures;
  exp_t exp_q[$];

  furv_id #(.XLEN(32), .HAZARD_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .instruction (instruction),
    .valid_i     (valid_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .id_pc       (id_pc),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .imm         (imm),
    .rd          (rd),
    .funct3      (funct3),
    .alu_alt     (alu_alt),
    .ctrl        (ctrl),
    .illegal     (illegal),
    .valid_o     (valid_o)
  );

  // Register file model: x0 reads 0, xN reads 0x100+N.
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : 32'h100 + {27'd0, a};
  endfunction

  assign rs1_data = rf(rs1_addr);
  assign rs2_data = rf(rs2_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input int lvl, input logic v, input logic [31:0] pc,
                              input logic [31:0] rs1v, input logic [31:0] rs2v,
                              input logic [31:0] im, input logic [4:0] r,
                              input logic [2:0] f3, input logic alt,
                              input logic [7:0] c, input logic il);
    exp_t e;
    e.lvl = lvl; e.valid = v; e.pc = pc; e.rs1v = rs1v; e.rs2v = rs2v;
    e.imm = im; e.rd = r; e.f3 = f3; e.alt = alt; e.ctrl = c; e.ill = il;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of fetch/execute inputs, check stall_o before the edge,
  // then compare the registered outputs just after it.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                      input logic v, input logic st, input logic fl, input logic r,
                      input logic exp_stall, input exp_t e);
    exp_t got;
    if_pc = pc; instruction = ins; valid_i = v; stall_i = st; flush_i = fl; rst = r;
    #3;
    if (!r) cmp({tag, ".stall_o"}, {31'd0, stall_o}, {31'd0, exp_stall});
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    cmp({tag, ".valid_o"}, {31'd0, valid_o}, {31'd0, got.valid});
    if (got.lvl >= 1) begin
      cmp({tag, ".id_pc"},   id_pc,   got.pc);
      cmp({tag, ".rs1_val"}, rs1_val, got.rs1v);
      cmp({tag, ".rs2_val"}, rs2_val, got.rs2v);
      cmp({tag, ".rd"},      {27'd0, rd},     {27'd0, got.rd});
      cmp({tag, ".funct3"},  {29'd0, funct3}, {29'd0, got.f3});
      cmp({tag, ".alu_alt"}, {31'd0, alu_alt}, {31'd0, got.alt});
      cmp({tag, ".ctrl"},    {24'd0, ctrl},   {24'd0, got.ctrl});
      cmp({tag, ".illegal"}, {31'd0, illegal}, {31'd0, got.ill});
    end
    if (got.lvl >= 2) cmp({tag, ".imm"}, imm, got.imm);
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LW2   = 32'h0000A103;  // lw x2,0(x1)
  localparam logic [31:0] I_ADD3  = 32'h002101B3;  // add x3,x2,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] I_ADD30 = 32'h000001B3;  // add x3,x0,x0
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3;  // beq x0,x0,-4
  localparam logic [31:0] I_SRAI  = 32'h4030D393;  // srai x7,x1,3
  localparam logic [31:0] I_SW    = 32'h0020A423;  // sw x2,8(x1)
  localparam logic [31:0] I_LW8   = 32'h00002403;  // lw x8,0(x0)
  localparam logic [31:0] I_LUI   = 32'h12345337;  // lui x6,0x12345 (rs1 field = 8)
  localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;

  initial begin
    exp_t rst_e, bub, addi_e;
    checks = 0;
    failures = 0;
    rst = 1'b1; if_pc = '0; instruction = '0; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

    rst_e  = mk(2, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0, 8'h00, 0);
    bub    = mk(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0, 8'h00, 0);
    addi_e = mk(2, 1, 32'h100, 32'h0, 32'h105, 32'h5, 5'd1, 3'd0, 0, 8'h01, 0);

    step("rst0", 32'h100, I_ADDI, 1, 0, 0, 1, 0, rst_e);
    step("rst1", 32'h100, I_ADDI, 1, 0, 0, 1, 0, rst_e);
    step("addi", 32'h100, I_ADDI, 1, 0, 0, 0, 0, addi_e);

    step("lw_x2", 32'h104, I_LW2, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h104, 32'h101, 32'h0, 32'h0, 5'd2, 3'd2, 0, 8'h04, 0));
    step("lu_bubble", 32'h108, I_ADD3, 1, 0, 0, 0, 1, bub);
    step("add_x3", 32'h108, I_ADD3, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h108, 32'h102, 32'h102, 32'h0, 5'd3, 3'd0, 0, 8'h00, 0));

    step("lw_x0", 32'h10C, I_LW0, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h10C, 32'h101, 32'h0, 32'h0, 5'd0, 3'd2, 0, 8'h04, 0));
    step("add_x0", 32'h110, I_ADD30, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h110, 32'h0, 32'h0, 32'h0, 5'd3, 3'd0, 0, 8'h00, 0));

    step("beq", 32'h114, I_BEQ, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h114, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 3'd0, 0, 8'h08, 0));

    step("flush_stall", 32'h118, I_ADDI, 1, 1, 1, 0, 1, bub);

    addi_e.pc = 32'h118;
    step("addi2", 32'h118, I_ADDI, 1, 0, 0, 0, 0, addi_e);
    step("hold0", 32'h11C, I_ADD3, 1, 1, 0, 0, 1, addi_e);
    step("hold1", 32'h11C, I_ADD3, 1, 1, 0, 0, 1, addi_e);
    step("hold2", 32'h11C, I_ADD3, 1, 1, 0, 0, 1, addi_e);

    step("srai", 32'h11C, I_SRAI, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h11C, 32'h101, 32'h103, 32'h403, 5'd7, 3'd5, 1, 8'h01, 0));
    step("sw", 32'h120, I_SW, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h120, 32'h101, 32'h102, 32'h8, 5'd0, 3'd2, 0, 8'h02, 0));
    step("lw_x8", 32'h124, I_LW8, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h124, 32'h0, 32'h0, 32'h0, 5'd8, 3'd2, 0, 8'h04, 0));
    step("lui", 32'h128, I_LUI, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h128, 32'h108, 32'h103, 32'h12345000, 5'd6, 3'd5, 0, 8'h80, 0));
    step("illegal", 32'h12C, I_ILL, 1, 0, 0, 0, 0,
         mk(1, 1, 32'h12C, 32'h11F, 32'h11F, 32'h0, 5'd0, 3'd7, 0, 8'h00, 1));

    step("lw_x2b", 32'h130, I_LW2, 1, 0, 0, 0, 0,
         mk(2, 1, 32'h130, 32'h101, 32'h0, 32'h0, 5'd2, 3'd2, 0, 8'h04, 0));
    step("lu_rs2", 32'h134, I_SW, 1, 0, 0, 0, 1, bub);
    step("rst_stall", 32'h134, I_SW, 1, 1, 0, 1, 0, rst_e);
    step("vi_low", 32'h138, I_ADDI, 0, 0, 0, 0, 0, bub);
    addi_e.pc = 32'h13C;
    step("addi3", 32'h13C, I_ADDI, 1, 0, 0, 0, 0, addi_e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
